// File: rtl/zuma_cfg_pkg.sv
// zuma_cfg_pkg: shared state encoding and helpers for the eLUT configuration sequencer
package zuma_cfg_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} cfg_state_e;
  localparam int MAX_LUTS = 64;
  function automatic int mask_w(input int lut_size);
    return 1 << lut_size;
  endfunction
  function automatic logic [MAX_LUTS-1:0] onehot(input int idx);
    return MAX_LUTS'(1) << idx;
  endfunction
endpackage

// File: rtl/zuma_cfg_bitcnt.sv
// zuma_cfg_bitcnt: LUT address counter with load, enable and terminal count at the last mask bit
module zuma_cfg_bitcnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] addr,
  output logic         tc
);
  logic [W:0] cnt_q, cnt_d;
  // load clears to address 0 and takes priority over counting
  always_comb cnt_d = load ? '0 : en ? cnt_q + (W+1)'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign addr = cnt_q[W-1:0];
  assign tc   = cnt_q == {1'b0, {W{1'b1}}};
endmodule

// File: rtl/zuma_lut_cfg_ctrl.sv
// zuma_lut_cfg_ctrl: writes one LUT mask bit-serially into an eLUT and optionally reads it back
module zuma_lut_cfg_ctrl
  import zuma_cfg_pkg::*;
#(
  parameter int ZUMA_LUT_SIZE = 6,
  parameter int NUM_LUTS      = 8,
  parameter int IDX_W         = 3,
  parameter int VERIFY_EN     = 1,
  localparam int MASK_W       = mask_w(ZUMA_LUT_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [IDX_W-1:0]         cfg_lut_idx,
  input  logic [MASK_W-1:0]        cfg_mask,
  input  logic                     cfg_abort,
  output logic [ZUMA_LUT_SIZE-1:0] lut_a,
  output logic                     lut_d,
  output logic [NUM_LUTS-1:0]      lut_we,
  output logic [ZUMA_LUT_SIZE-1:0] lut_dpra,
  output logic                     cfg_mode,
  input  logic [NUM_LUTS-1:0]      lut_dpo,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);
  cfg_state_e               state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [MASK_W-1:0]        mask_q, mask_d;
  logic                     err_q, err_d;
  logic                     error_q, error_d;
  logic                     rdy_q, rdy_d;
  logic                     cnt_ld, cnt_en, cnt_tc;
  logic [ZUMA_LUT_SIZE-1:0] cnt;
  logic [NUM_LUTS-1:0]      sel;
  logic                     rd_bit;

  zuma_cfg_bitcnt #(.W(ZUMA_LUT_SIZE)) u_bitcnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (cnt_ld),
    .en   (cnt_en),
    .addr (cnt),
    .tc   (cnt_tc)
  );

  assign sel    = NUM_LUTS'(onehot(int'(idx_q)));
  assign rd_bit = |(lut_dpo & sel);

  // next-state: accept, serial write, read-back sweep, one-cycle completion; abort wins over the last bit
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    err_d   = err_q;
    error_d = error_q;
    rdy_d   = 1'b1;
    cnt_ld  = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: if (cfg_valid && cfg_ready) begin
        idx_d   = cfg_lut_idx;
        mask_d  = cfg_mask;
        err_d   = int'(cfg_lut_idx) >= NUM_LUTS;
        error_d = 1'b0;
        cnt_ld  = 1'b1;
        state_d = err_d ? DONE : WRITE;
      end
      WRITE: begin
        cnt_en = 1'b1;
        err_d  = err_q | cfg_abort;
        if (cnt_tc || cfg_abort) begin
          cnt_ld  = 1'b1;
          state_d = (cfg_abort || VERIFY_EN == 0) ? DONE : VERIFY;
        end
      end
      VERIFY: begin
        cnt_en = 1'b1;
        err_d  = err_q | cfg_abort | (rd_bit != mask_q[cnt]);
        if (cnt_tc || cfg_abort) begin
          cnt_ld  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == DONE) error_d = err_d;
  end

  // state and transaction registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      error_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      error_q <= error_d;
      rdy_q   <= rdy_d;
    end

  assign cfg_ready = rdy_q && state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign cfg_mode  = state_q == VERIFY;
  assign lut_a     = state_q == WRITE ? cnt : '0;
  assign lut_d     = state_q == WRITE && mask_q[cnt];
  assign lut_we    = state_q == WRITE ? sel : '0;
  assign lut_dpra  = state_q == VERIFY ? cnt : '0;
  assign error     = error_q;
endmodule

// File: tb/tb_zuma_lut_cfg_ctrl.sv
// tb_zuma_lut_cfg_ctrl: randomized self-checking bench with eLUT models and a transaction-level reference
module tb_zuma_lut_cfg_ctrl;
  localparam int N  = 8;
  localparam int L  = 6;
  localparam int MW = 64;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_valid = 1'b0, cfg_abort = 1'b0;
  logic [IW-1:0] cfg_lut_idx = '0;
  logic [MW-1:0] cfg_mask = '0;
  logic cfg_ready, lut_d, cfg_mode, busy, done, error;
  logic [L-1:0] lut_a, lut_dpra;
  logic [N-1:0] lut_we, lut_dpo;

  logic nv_valid = 1'b0;
  logic nv_ready, nv_d, nv_mode, nv_busy, nv_done, nv_error;
  logic [L-1:0] nv_a, nv_dpra;
  logic [N-1:0] nv_we;

  logic [L-1:0] dp_addr = '0, rd;
  logic stuck_en = 1'b0;
  int stuck_lut = 0, stuck_addr = 0;
  logic [MW-1:0] mem [N];
  logic [MW-1:0] ref_mem [N];
  logic [MW-1:0] ref_def [N];
  int nchk = 0, nfail = 0;

  always #5 clk = ~clk;

  zuma_lut_cfg_ctrl #(.ZUMA_LUT_SIZE(L), .NUM_LUTS(N), .IDX_W(IW), .VERIFY_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_lut_idx(cfg_lut_idx), .cfg_mask(cfg_mask), .cfg_abort(cfg_abort),
    .lut_a(lut_a), .lut_d(lut_d), .lut_we(lut_we), .lut_dpra(lut_dpra),
    .cfg_mode(cfg_mode), .lut_dpo(lut_dpo), .busy(busy), .done(done), .error(error)
  );

  zuma_lut_cfg_ctrl #(.ZUMA_LUT_SIZE(L), .NUM_LUTS(N), .IDX_W(IW), .VERIFY_EN(0)) u_nv (
    .clk(clk), .rst_n(rst_n), .cfg_valid(nv_valid), .cfg_ready(nv_ready),
    .cfg_lut_idx(4'd1), .cfg_mask(64'hF0F0_1234_5678_9ABC), .cfg_abort(1'b0),
    .lut_a(nv_a), .lut_d(nv_d), .lut_we(nv_we), .lut_dpra(nv_dpra),
    .cfg_mode(nv_mode), .lut_dpo(8'h00), .busy(nv_busy), .done(nv_done), .error(nv_error)
  );

  // eLUT models: synchronous write, asynchronous read through the cfg_mode mux, optional stuck-at-0 cell
  always @(posedge clk)
    for (int k = 0; k < N; k++) if (lut_we[k]) mem[k][lut_a] <= lut_d;
  assign rd = cfg_mode ? lut_dpra : dp_addr;
  always_comb
    for (int k = 0; k < N; k++)
      lut_dpo[k] = mem[k][rd] & ~(stuck_en && stuck_lut == k && int'(rd) == stuck_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int c = 0;
    @(negedge clk);
    while (!cfg_ready && c < 400) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic run(input logic [IW-1:0] idx, input logic [MW-1:0] mask, input int abort_at,
                     output int dcyc, output int wcyc, output int wbad, output logic err);
    dcyc = -1; wcyc = 0; wbad = 0; err = 1'b0;
    wait_ready();
    if (!cfg_ready) return;
    cfg_valid = 1'b1; cfg_lut_idx = idx; cfg_mask = mask;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (lut_we != 0) wcyc++;
      if (lut_we != 0 && lut_we != (8'd1 << idx)) wbad++;
      if (done) begin
        dcyc = k;
        err = error;
        break;
      end
      cfg_abort = k == abort_at;
    end
    cfg_abort = 1'b0;
  endtask

  function automatic int bad_luts();
    int n = 0;
    for (int k = 0; k < N; k++) if ((mem[k] & ref_def[k]) !== (ref_mem[k] & ref_def[k])) n++;
    return n;
  endfunction

  // reference: a transaction writes bit i in cycle i+1, verifies in 65..128, completes the cycle after its last activity
  task automatic txn(input string tag, input int idx, input logic [MW-1:0] mask, input int abort_at);
    int dcyc, wcyc, wbad, edone, ewe, nw;
    logic err, eerr;
    run(IW'(idx), mask, abort_at, dcyc, wcyc, wbad, err);
    if (idx >= N) begin
      edone = 1; eerr = 1'b1; ewe = 0; nw = 0;
    end else if (abort_at >= 1 && abort_at <= 128) begin
      edone = abort_at + 1; eerr = 1'b1;
      ewe = abort_at < MW ? abort_at : MW; nw = ewe;
    end else begin
      edone = 129; ewe = MW; nw = MW;
      eerr = stuck_en && stuck_lut == idx && mask[stuck_addr];
    end
    for (int i = 0; i < nw; i++) begin
      ref_mem[idx][i] = mask[i];
      ref_def[idx][i] = 1'b1;
    end
    chk({tag, "_done_cyc"}, 64'(dcyc), 64'(edone));
    chk({tag, "_error"}, 64'(err), 64'(eerr));
    chk({tag, "_we_cycles"}, 64'(wcyc), 64'(ewe));
    chk({tag, "_we_onehot"}, 64'(wbad), 64'd0);
    chk({tag, "_lut_contents"}, 64'(bad_luts()), 64'd0);
    @(negedge clk);
    chk({tag, "_ready_after_done"}, 64'(cfg_ready), 64'd1);
  endtask

  initial begin
    int fr, dk, d2;
    logic derr, e2;
    logic [MW-1:0] ma, mb;
    for (int k = 0; k < N; k++) begin
      ref_mem[k] = '0;
      ref_def[k] = '0;
    end
    #12;
    chk("rst_ready", 64'(cfg_ready), 64'd0);
    chk("rst_we", 64'(lut_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_mode", 64'(cfg_mode), 64'd0);
    chk("rst_a_d_dpra", 64'({lut_a, lut_d, lut_dpra}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(cfg_ready), 64'd1);

    txn("idx3", 3, 64'hDEADBEEF_0123_4567, -1);
    dp_addr = 6'd0;
    #1 chk("dp_lut3_a0", 64'(lut_dpo[3]), 64'd1);
    dp_addr = 6'd4;
    #1 chk("dp_lut3_a4", 64'(lut_dpo[3]), 64'd0);

    stuck_en = 1'b1; stuck_lut = 5; stuck_addr = 17;
    txn("stuck5", 5, '1, -1);
    stuck_en = 1'b0;

    txn("oor9", 9, 64'h1234_5678_9ABC_DEF0, -1);
    txn("abort20", 1, 64'hA5A5_0F0F_3C3C_9696, 20);
    txn("abort_last_wr", 2, 64'h8000_0000_0000_0001, 64);
    txn("abort_last_vf", 4, 64'h0123_4567_89AB_CDEF, 128);

    wait_ready();
    cfg_valid = 1'b1; cfg_lut_idx = 4'd2; cfg_mask = 64'hFFFF_0000_FFFF_0000;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    for (int k = 1; k <= 40; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", 64'(lut_we), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_mode", 64'(cfg_mode), 64'd0);
    dk = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) dk++;
    end
    chk("midrst_no_done", 64'(dk), 64'd0);
    ref_def[2] = '0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 64'(cfg_ready), 64'd1);
    txn("after_rst_idx0", 0, {$urandom, $urandom}, -1);

    ma = {$urandom, $urandom};
    mb = {$urandom, $urandom};
    wait_ready();
    cfg_valid = 1'b1; cfg_lut_idx = 4'd2; cfg_mask = ma;
    @(posedge clk);
    fr = -1; dk = -1; derr = 1'b1; d2 = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (lut_we != 0 && lut_we != 8'h04) d2++;
      if (done) begin
        dk = k;
        derr = error;
      end
      if (cfg_ready) begin
        fr = k;
        break;
      end
      cfg_lut_idx = k == 129 ? 4'd6 : IW'($urandom_range(0, 7));
      cfg_mask = k == 129 ? mb : {$urandom, $urandom};
    end
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    chk("b2b_first_ready", 64'(fr), 64'd130);
    chk("b2b_first_done", 64'(dk), 64'd129);
    chk("b2b_first_error", 64'(derr), 64'd0);
    chk("b2b_we_ignores_busy_req", 64'(d2), 64'd0);
    e2 = 1'b1; dk = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (done) begin
        dk = k;
        e2 = error;
        break;
      end
    end
    chk("b2b_second_done", 64'(dk), 64'd129);
    chk("b2b_second_error", 64'(e2), 64'd0);
    ref_mem[2] = ma; ref_def[2] = '1;
    ref_mem[6] = mb; ref_def[6] = '1;
    chk("b2b_lut_contents", 64'(bad_luts()), 64'd0);

    @(negedge clk);
    dk = 0;
    while (!nv_ready && dk < 400) begin
      @(negedge clk);
      dk++;
    end
    nv_valid = 1'b1;
    @(posedge clk);
    #1 nv_valid = 1'b0;
    dk = -1; e2 = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (nv_done) begin
        dk = k;
        e2 = nv_error;
        break;
      end
    end
    chk("noverify_done_cyc", 64'(dk), 64'd65);
    chk("noverify_error", 64'(e2), 64'd0);

    for (int t = 0; t < 8; t++) begin
      stuck_en = 1'($urandom_range(0, 1));
      stuck_lut = $urandom_range(0, N - 1);
      stuck_addr = $urandom_range(0, MW - 1);
      txn($sformatf("rnd%0d", t), $urandom_range(0, 9), {$urandom, $urandom},
          $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 128)) : -1);
    end
    stuck_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/zuma_lut_cfg_ctrl.md
Name: zuma_lut_cfg_ctrl

Overview:
- Configuration sequencer for the array of LUTRAM-based eLUTs in the overlay.
- Accepts one LUT mask per transaction on a valid/ready interface.
- Writes the mask bit-serially through the selected eLUT's write port (a/d/we), then optionally reads it back through the dpra/dpo path and flags mismatches.
- Sits between the overlay config loader and the eLUT write/read ports. Owns dpra muxing while cfg_mode=1.

Parameters:
- ZUMA_LUT_SIZE, 6, LUT input count; mask width MASK_W=2**ZUMA_LUT_SIZE.
- NUM_LUTS, 8, number of eLUTs driven.
- IDX_W, 3, width of LUT index (>= clog2(NUM_LUTS)).
- VERIFY_EN, 1, 1 = read-back phase after write; 0 = skip it.

Ports:
- clk  in  1  configuration/LUTRAM write clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  request valid.
- cfg_ready  out  1  high only in IDLE.
- cfg_lut_idx  in  IDX_W  target eLUT.
- cfg_mask  in  MASK_W  LUT mask; bit i = output for address i.
- cfg_abort  in  1  synchronous abort of the current transaction.
- lut_a  out  ZUMA_LUT_SIZE  shared write address to all eLUTs.
- lut_d  out  1  shared write data.
- lut_we  out  NUM_LUTS  one-hot write enable.
- lut_dpra  out  ZUMA_LUT_SIZE  read address driven during verify.
- cfg_mode  out  1  1 = datapath dpra muxed to lut_dpra.
- lut_dpo  in  NUM_LUTS  asynchronous read outputs of all eLUTs.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  result of the last transaction; held until the next accept.

Behaviour:
- Reset (async, rst_n=0), all outputs forced immediately:
  - cfg_ready=0 during reset, 1 in the first cycle after release.
  - lut_we=0, lut_a=0, lut_d=0, lut_dpra=0, cfg_mode=0, busy=0, done=0, error=0.
  - Counter cleared; state=IDLE.
- States: IDLE, WRITE, VERIFY, DONE.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready: latch mask and index, clear err, cnt=0.
  - Next state WRITE if idx<NUM_LUTS; otherwise DONE with err=1. No write occurs for an out-of-range index.
- WRITE, one bit per cycle, cnt 0..MASK_W-1:
  - lut_a=cnt, lut_d=mask[cnt].
  - lut_we=one-hot(idx), registered outputs aligned in the same cycle.
  - After cnt=MASK_W-1: go to VERIFY (VERIFY_EN=1) or DONE, with cnt=0.
- VERIFY:
  - cfg_mode=1, lut_dpra=cnt.
  - Same-cycle compare lut_dpo[idx] vs mask[cnt]; dpo is combinational from dpra.
  - Mismatch sets sticky err; the sweep always completes all MASK_W addresses.
  - Then go to DONE.
- DONE: done=1 for exactly one cycle, error<=err, then IDLE.
- busy=1 in WRITE, VERIFY and DONE.
- Latency (accept edge = cycle 0):
  - Writes in cycles 1..64.
  - Verify in cycles 65..128.
  - done in cycle 129; cfg_ready=1 in cycle 130.
  - With VERIFY_EN=0: done in cycle 65.
- cfg_abort in WRITE/VERIFY:
  - Next cycle lut_we=0, cfg_mode=0, state DONE, err=1.
  - LUT contents are partially written and undefined.
  - Abort in IDLE/DONE is ignored.
- Abort and last-bit write in the same cycle: abort wins (error=1), but the last write still occurs.
- cfg_valid during busy: ignored; no queueing.
- Requester must hold the handshake signals stable until accepted.
- Counter width ZUMA_LUT_SIZE+1; no wrap ambiguity at MASK_W-1.
- Reset mid-operation: immediate IDLE, lut_we drops asynchronously, no done pulse.

Decomposition:
- Shared package zuma_cfg_pkg:
  - State enum (IDLE/WRITE/VERIFY/DONE).
  - MASK_W derivation.
  - One-hot decode function.
- One sub-module: zuma_cfg_bitcnt, the address counter with load, enable and terminal-count output, reused by WRITE and VERIFY.
- The bench instantiates NUM_LUTS eLUT models (used=1) on lut_a/lut_d/lut_we/lut_dpra.

Test Plan:
- Write idx=3, mask=64'hDEADBEEF_0123_4567, VERIFY_EN=1:
  - lut_we==8'h08 for 64 cycles.
  - done at cycle 129, error=0.
  - Datapath read of eLUT3 at address 0 returns 1, address 4 returns 0.
- Write idx=5 with eLUT5 model forced stuck-at-0 at address 17, mask=all ones:
  - Verify runs all 64 cycles.
  - done at 129, error=1.
- cfg_lut_idx=9, NUM_LUTS=8:
  - No lut_we activity.
  - done at cycle 1, error=1, cfg_ready at cycle 2.
- cfg_abort at cycle 20 of WRITE:
  - lut_we=0 at cycle 21.
  - done at cycle 21, error=1; next request accepted at cycle 22.
- rst_n low at cycle 40 of WRITE:
  - lut_we, busy, cfg_mode drop asynchronously; no done.
  - After release, cfg_ready=1 and a new idx=0 request completes with error=0.
- Back-to-back requests with cfg_valid held:
  - Second request accepted only at cfg_ready (cycle 130).
  - Requests sent while busy are ignored.
  - VERIFY_EN=0 build shows done at 65.
